// File: rtl/draw_lives_row_pkg.sv
// lives_pkg: shared colour key and blink FSM state type for the lives row
package lives_pkg;
  localparam logic [11:0] TRANSPARENT_COLOR = 12'hFFF;
  typedef enum logic {IDLE, BLINK} blink_state_e;
endpackage

// File: rtl/draw_lives_row_if.sv
// draw_lives_row_if: one video stream beat (timing plus colour)
interface draw_lives_row_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;
  modport master(output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave(input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// delay: fixed-length register pipeline with synchronous clear
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe_q [CLK_DEL];
  logic [WIDTH-1:0] pipe_d [CLK_DEL];
  // shift the pipeline by one stage
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) pipe_d[i] = pipe_q[i-1];
  end
  // stage registers, all cleared on reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < CLK_DEL; i++) pipe_q[i] <= rst ? '0 : pipe_d[i];
  end
  assign dout = pipe_q[CLK_DEL-1];
endmodule

// File: rtl/draw_lives_row_blink_ctrl.sv
// lives_blink_ctrl: frame-latched lives count and lost-life blink sequencer
module lives_blink_ctrl
  import lives_pkg::*;
#(
  parameter int MAX_LIVES    = 3,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic [3:0] dead_count,
  output logic [3:0] dc_lat,
  output logic [3:0] lives_left,
  output logic [3:0] blink_idx,
  output logic       blink_on,
  output logic       blink_active
);
  localparam int HB = $clog2(BLINK_HALF);
  localparam int FW = $clog2(BLINK_FRAMES) + HB + 1;
  localparam logic [3:0] MAXL = 4'(MAX_LIVES);
  localparam logic [FW-1:0] LAST = FW'(BLINK_FRAMES - 1);
  blink_state_e state_q, state_d;
  logic vblnk_q, vblnk_d, tick;
  logic [3:0] dc_q, dc_d, bidx_q, bidx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  function automatic logic [3:0] left(input logic [3:0] dc);
    return dc >= MAXL ? 4'd0 : MAXL - dc;
  endfunction
  assign tick = vblnk & ~vblnk_q;
  assign dc_lat = dc_q;
  assign lives_left = left(dc_q);
  assign blink_idx = bidx_q;
  assign blink_active = state_q == BLINK;
  assign blink_on = blink_active & ~fcnt_q[HB];
  // latch the count and advance the blink only on the start of vertical blank
  always_comb begin
    vblnk_d = vblnk;
    dc_d = dc_q;
    state_d = state_q;
    fcnt_d = fcnt_q;
    bidx_d = bidx_q;
    if (tick) begin
      dc_d = dead_count;
      if (dead_count < dc_q) state_d = IDLE;
      else if (dead_count > dc_q && dc_q < MAXL) begin
        state_d = BLINK;
        bidx_d = left(dead_count);
        fcnt_d = '0;
      end else if (state_q == BLINK) begin
        state_d = fcnt_q == LAST ? IDLE : BLINK;
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end
  // blink state registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      vblnk_q <= 1'b0;
      dc_q <= '0;
      bidx_q <= '0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      vblnk_q <= vblnk_d;
      dc_q <= dc_d;
      bidx_q <= bidx_d;
      fcnt_q <= fcnt_d;
    end
  end
endmodule

// File: rtl/draw_lives_row.sv
// draw_lives_row: overlays a row of life icons from a sprite ROM on the video stream
module draw_lives_row
  import lives_pkg::*;
#(
  parameter int MAX_LIVES    = 3,
  parameter int XPOS         = 20,
  parameter int YPOS         = 50,
  parameter int ICON_W_LOG2  = 5,
  parameter int ICON_H_LOG2  = 5,
  parameter int SPACING      = 8,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8
) (
  input  logic                               pclk,
  input  logic                               rst,
  input  logic [3:0]                         dead_count,
  draw_lives_row_if.slave                    vin,
  draw_lives_row_if.master                   vout,
  input  logic [11:0]                        rgb_pixel,
  output logic [ICON_W_LOG2+ICON_H_LOG2-1:0] pixel_addr,
  output logic [3:0]                         dead_count_out,
  output logic                               blink_active
);
  localparam int W = ICON_W_LOG2;
  localparam int H = ICON_H_LOG2;
  localparam int PITCH = (1 << W) + SPACING;
  localparam logic [10:0] XW = 11'(1 << W);
  localparam logic [10:0] YH = 11'(1 << H);
  localparam logic [10:0] Y0 = 11'(YPOS);
  logic [3:0] lives_left, blink_idx, idx;
  logic blink_on, hit, vis;
  logic [10:0] x0, dx, dy;
  logic [W-1:0] dx_hit;
  logic [W+H-1:0] addr_q, addr_d;
  logic vis1_q, vis1_d, vis2_q, vis2_d, blank1_q, blank1_d, blank2_q, blank2_d;
  logic [11:0] rgb1_q, rgb1_d, rgb2_q, rgb2_d, rgb_out_q, rgb_out_d;
  logic [25:0] tim_q;
  lives_blink_ctrl #(
    .MAX_LIVES(MAX_LIVES), .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
  ) u_ctrl (
    .pclk(pclk), .rst(rst), .vblnk(vin.vblnk), .dead_count(dead_count),
    .dc_lat(dead_count_out), .lives_left(lives_left), .blink_idx(blink_idx),
    .blink_on(blink_on), .blink_active(blink_active)
  );
  delay #(.WIDTH(26), .CLK_DEL(3)) u_dly (
    .clk(pclk), .rst(rst),
    .din({vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk}),
    .dout(tim_q)
  );
  assign {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk} = tim_q;
  assign vout.rgb = rgb_out_q;
  assign pixel_addr = addr_q;
  // slot hit test, ROM address and three-stage colour pipeline
  always_comb begin
    hit = 1'b0;
    idx = '0;
    dx_hit = '0;
    x0 = '0;
    dx = '0;
    dy = vin.vcount - Y0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      x0 = 11'(XPOS + i * PITCH);
      dx = vin.hcount - x0;
      if (vin.hcount >= x0 && dx < XW && vin.vcount >= Y0 && dy < YH) begin
        hit = 1'b1;
        idx = 4'(i);
        dx_hit = dx[W-1:0];
      end
    end
    vis = hit && (idx < lives_left || (idx == blink_idx && blink_on));
    addr_d = hit ? {dy[H-1:0], dx_hit} : addr_q;
    vis1_d = vis;
    blank1_d = vin.hblnk | vin.vblnk;
    rgb1_d = vin.rgb;
    vis2_d = vis1_q;
    blank2_d = blank1_q;
    rgb2_d = rgb1_q;
    rgb_out_d = blank2_q ? 12'h000 :
                (vis2_q && rgb_pixel != TRANSPARENT_COLOR) ? rgb_pixel : rgb2_q;
  end
  // pipeline registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      addr_q <= '0;
      vis1_q <= 1'b0;
      vis2_q <= 1'b0;
      blank1_q <= 1'b0;
      blank2_q <= 1'b0;
      rgb1_q <= '0;
      rgb2_q <= '0;
      rgb_out_q <= '0;
    end else begin
      addr_q <= addr_d;
      vis1_q <= vis1_d;
      vis2_q <= vis2_d;
      blank1_q <= blank1_d;
      blank2_q <= blank2_d;
      rgb1_q <= rgb1_d;
      rgb2_q <= rgb2_d;
      rgb_out_q <= rgb_out_d;
    end
  end
endmodule

// File: doc/draw_lives_row.md
Name: draw_lives_row

Overview:
- Successor to the single-icon life indicator. Draws a row of up to MAX_LIVES ship icons from a shared sprite ROM onto the video stream.
- Hides lost lives and blinks the icon of a just-lost life for a fixed number of frames.
- Sits in the video pipeline after the background/ship drawers. Passes all timing signals through with a fixed 3-cycle latency.
- Samples dead_count once per frame, so the row never tears mid-frame.

Parameters:
MAX_LIVES, 3, number of icon slots (1..15)
XPOS, 20, left x of slot 0
YPOS, 50, top y of all slots
ICON_W_LOG2, 5, icon width = 2^ICON_W_LOG2 pixels
ICON_H_LOG2, 5, icon height = 2^ICON_H_LOG2 pixels
SPACING, 8, horizontal gap in pixels between slots
BLINK_FRAMES, 60, frames a lost icon blinks
BLINK_HALF, 8, frames per on/off half-period (power of two)

Ports:
pclk  in  1  pixel clock; single clock domain
rst  in  1  synchronous, active-high reset
dead_count  in  4  lives lost so far
hcount_in, vcount_in  in  11 each  pixel counters
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  sync/blank
rgb_in  in  12  background colour
rgb_pixel  in  12  ROM data, valid 1 cycle after pixel_addr (registered ROM)
hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  as inputs  timing, delayed 3 cycles
rgb_out  out  12  composited colour
pixel_addr  out  ICON_W_LOG2+ICON_H_LOG2  ROM address {y_off, x_off}
dead_count_out  out  4  frame-latched dead_count
blink_active  out  1  high while a blink is running

Behaviour:
- Reset (rst high at a pclk edge): every output register is 0, FSM is IDLE, frame counter is 0, latched dead_count is 0.
- Reset mid-blink aborts the blink; blink_active goes low on that edge.
- Pipeline, for inputs sampled at edge k:
  - S1 (edge k+1): compute slot hit and slot index; register pixel_addr; delay timing and rgb_in.
  - S2 (edge k+2): rgb_pixel is valid; carry hit/visible/blank forward.
  - S3 (edge k+3): register rgb_out and all timing outputs.
- Slot geometry: slot i occupies x in [XPOS+i*(2^W+SPACING), that value + 2^W - 1] and y in [YPOS, YPOS+2^H-1]. Ranges are inclusive/exclusive exactly as written, so each slot is exactly 2^W x 2^H pixels with no extra column or row.
- Offsets: x_off = hcount - slot_x0 and y_off = vcount - YPOS, both truncated to W and H bits. Outside any slot, pixel_addr holds its last value (don't-care for the ROM).
- Frame tick: the rising edge of vblnk_in, detected with a 1-cycle registered copy. On the tick, dead_count is latched into dc_lat, and dead_count_out follows dc_lat.
- lives_left = MAX_LIVES - dc_lat, saturating at 0.
- Slot i is visible if i < lives_left, or if it is the blinking slot in its "on" phase.
- Colour mux at S3, in priority order:
  - delayed blank (hblnk or vblnk) → 0;
  - visible hit and rgb_pixel != 12'hFFF → rgb_pixel;
  - otherwise → delayed rgb_in.
- Blink FSM, states IDLE and BLINK, evaluated only on frame ticks:
  - IDLE → BLINK when the new dc_lat > the old dc_lat and the old dc_lat < MAX_LIVES. Set blink_idx = new lives_left (the highest lost slot) and fcnt = 0.
  - In BLINK, each tick does fcnt++. Phase "on" = (fcnt / BLINK_HALF) even, so the icon is on for frames 0..BLINK_HALF-1.
  - BLINK → IDLE when fcnt reaches BLINK_FRAMES-1.
  - Another increase while in BLINK restarts the blink: blink_idx is updated and fcnt = 0. The previous icon disappears immediately.
  - A decrease of dc_lat (game restart) → IDLE, no blink.
  - A jump of 2 or more blinks only the highest lost slot.
  - dc_lat >= MAX_LIVES: all slots hidden except a still-running blink.
- blink_active = (state == BLINK); it is registered.

Decomposition:
- Package lives_pkg holds TRANSPARENT_COLOR = 12'hFFF and the blink state enum (IDLE, BLINK).
- Sub-module lives_blink_ctrl owns the frame-tick detect, dc_lat, the FSM, fcnt and blink_idx. Its outputs are lives_left, blink_idx, blink_on and blink_active.
- The timing delay reuses the existing delay module.

Test Plan:
- Defaults, dc_lat=0, pixel (61,52) → pixel_addr = 65 ({2,1}) at edge +1. With rgb_pixel = 12'h0F0 at edge +2, rgb_out = 12'h0F0 at edge +3; timing outputs equal the inputs delayed by 3.
- x=52..59 (gap) and x=92 (first column past slot 1) → rgb_out = rgb_in. A rgb_pixel of 12'hFFF inside a slot → rgb_out = rgb_in. Any blank → rgb_out = 0.
- dead_count 0→1 mid-frame → no change until the next vblnk rise; slot 2 then blinks, on for frames 0-7 and off for frames 8-15. After 60 ticks blink_active=0 and slot 2 stays hidden.
- During a blink, dead_count 1→2 → blink restarts on slot 1 with fcnt=0, and slot 2 is hidden immediately.
- dead_count 3→0 → all three slots are visible next frame with no blink. Assert rst during a blink → all outputs are 0 and the FSM is IDLE on the next edge.
